// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Sequences one pipeline memory access at a time onto a single-port,
//   word-wide synchronous memory. Loads take one read. Word stores take one
//   write. Sub-word stores run read-modify-write: read, merge the new lane,
//   then write. Lanes are big-endian: byte offset 0 is bits [31:24] and half
//   offset 0 is bits [31:16].
//
//   Handshake: the pipeline raises Req with the request fields and keeps them
//   stable while Stall is high. Stall = Req & ~Done. The access completes in
//   the cycle Done pulses. Req, Addr and WData are only sampled in IDLE.
//
//   Optional feature: define MISALIGN_TRAP_EN to reject misaligned word or
//   half accesses. A rejected access completes in one cycle with Misalign
//   and Done, and issues no MemEn. When the macro is undefined, misaligned
//   low address bits are forced aligned and Misalign is tied to 0.
//
// Ports
//   Clk, Rst_n          clock (rising edge), async active-low reset
//   Req                 access request from the pipeline
//   MemRead, MemWrite   load / store (both high = store, neither = no-op)
//   MemSize             00 word, 01 half, 10 byte, 11 word
//   Addr, WData         byte address, right-justified store data
//   RData               load result (sign-extended lb/lh), held between loads
//   Done, Stall         completion pulse, pipeline freeze
//   Misalign            rejected-access flag, pulses with Done
//   MemEn, MemWe        registered memory enable / write enable
//   MemAddr, MemWData   registered word address (bits [1:0]=0) / write data
//   MemRDataIn          read data, valid the cycle after MemEn
//   DbgState            current FSM state, for observation

module mem_access_sequencer (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Done,
  output logic        Stall,
  output logic        Misalign,
  output logic        MemEn,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRDataIn,
  output logic [2:0]  DbgState
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  // Request fields latched in IDLE
  logic [1:0]  off_q;
  logic        half_q;
  logic        byte_q;
  logic        store_q;
  logic [15:0] wdata_q;

  // Incoming request decode (only meaningful in IDLE)
  logic        req_half_d;
  logic        req_byte_d;
  logic        req_word_d;
  logic [1:0]  off_d;
  logic        trap_d;

  // Lane extraction / merge on the returning read word
  logic [7:0]  lane_byte_d;
  logic [15:0] lane_half_d;
  logic [31:0] load_data_d;
  logic [31:0] merge_data_d;

  assign req_half_d = (MemSize == 2'b01);
  assign req_byte_d = (MemSize == 2'b10);
  assign req_word_d = ~req_half_d & ~req_byte_d;

  // Misaligned low bits are dropped; in the trap build a misaligned access
  // never gets past IDLE, so the forced value only matters otherwise.
  always_comb begin
    off_d = Addr[1:0];
    if (req_word_d)      off_d = 2'b00;
    else if (req_half_d) off_d = {Addr[1], 1'b0};
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap_d = (MemRead | MemWrite) &
                  ((req_word_d & (Addr[1:0] != 2'b00)) | (req_half_d & Addr[0]));

  // Set on the rejecting IDLE cycle so it lines up with Done in DONE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      misalign_q <= 1'b0;
    end else if (state_q == S_IDLE && Req) begin
      misalign_q <= trap_d;
    end else if (state_q == S_DONE) begin
      misalign_q <= 1'b0;
    end
  end

  assign Misalign = misalign_q;
`else
  assign trap_d   = 1'b0;
  assign Misalign = 1'b0;
`endif

  always_comb begin
    lane_byte_d = MemRDataIn[7:0];
    case (off_q)
      2'd0:    lane_byte_d = MemRDataIn[31:24];
      2'd1:    lane_byte_d = MemRDataIn[23:16];
      2'd2:    lane_byte_d = MemRDataIn[15:8];
      default: lane_byte_d = MemRDataIn[7:0];
    endcase
    lane_half_d = off_q[1] ? MemRDataIn[15:0] : MemRDataIn[31:16];

    if (byte_q)      load_data_d = {{24{lane_byte_d[7]}}, lane_byte_d};
    else if (half_q) load_data_d = {{16{lane_half_d[15]}}, lane_half_d};
    else             load_data_d = MemRDataIn;

    merge_data_d = MemRDataIn;
    if (byte_q) begin
      case (off_q)
        2'd0:    merge_data_d[31:24] = wdata_q[7:0];
        2'd1:    merge_data_d[23:16] = wdata_q[7:0];
        2'd2:    merge_data_d[15:8]  = wdata_q[7:0];
        default: merge_data_d[7:0]   = wdata_q[7:0];
      endcase
    end else if (half_q) begin
      if (off_q[1]) merge_data_d[15:0]  = wdata_q;
      else          merge_data_d[31:16] = wdata_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      off_q       <= 2'b00;
      half_q      <= 1'b0;
      byte_q      <= 1'b0;
      store_q     <= 1'b0;
      wdata_q     <= 16'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q   <= 1'b0;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (Req) begin
            off_q   <= off_d;
            half_q  <= req_half_d;
            byte_q  <= req_byte_d;
            store_q <= MemWrite;
            wdata_q <= WData[15:0];
            if (trap_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (MemWrite && req_word_d) begin
              mem_addr_q  <= {Addr[31:2], 2'b00};
              mem_wdata_q <= WData;
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              state_q     <= S_WR;
            end else if (MemWrite || MemRead) begin
              // Loads and the read half of a read-modify-write
              mem_addr_q <= {Addr[31:2], 2'b00};
              mem_en_q   <= 1'b1;
              state_q    <= S_RD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RD: begin
          mem_en_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (store_q) begin
            mem_wdata_q <= merge_data_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= S_WR;
          end else begin
            rdata_q <= load_data_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WR: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RData    = rdata_q;
  assign Done     = done_q;
  assign Stall    = Req & ~done_q;
  assign MemEn    = mem_en_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign DbgState = state_q;

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1 bit: sole clock, rising-edge.
REQ-002 SHALL have port Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port Req, input, 1 bit: pipeline requests a memory access this cycle.
REQ-004 SHALL have port MemRead, input, 1 bit: load request, from controller.
REQ-005 SHALL have port MemWrite, input, 1 bit: store request, from controller.
REQ-006 SHALL have port MemSize, input, 2 bits: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-007 SHALL have port Addr, input, 32 bits: byte address from the ALU.
REQ-008 SHALL have port WData, input, 32 bits: store data, right-justified for sub-word stores.
REQ-009 SHALL have port RData, output, 32 bits: load result, sign-extended for lb/lh.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port Stall, output, 1 bit: combinational, equal to Req & ~Done; freezes the pipeline.
REQ-012 SHALL have port Misalign, output, 1 bit: pulses with Done on a rejected misaligned access.
REQ-013 SHALL have memory-side outputs MemEn (1 bit), MemWe (1 bit), MemAddr (32 bits, bits[1:0]=00) and MemWData (32 bits), plus input MemRDataIn (32 bits), valid the cycle after MemEn.

Function
REQ-014 SHALL implement the FSM states IDLE, RD, WAIT, WR and DONE, with all memory-side outputs registered.
REQ-015 In IDLE, Req SHALL latch Addr, WData and MemSize and branch as follows: load -> RD; word store -> WR; sub-word store -> RD; neither read nor write -> DONE.
REQ-016 If MemRead and MemWrite are both high, the access SHALL be treated as a store.
REQ-017 RD SHALL drive MemEn=1 and MemWe=0 for one cycle, then go to WAIT.
REQ-018 WAIT for a load SHALL capture the selected lane into RData, then go to DONE.
REQ-019 WAIT for a sub-word store SHALL merge WData into the lane of MemRDataIn, then go to WR.
REQ-020 WR SHALL drive MemEn=1, MemWe=1 and MemWData for one cycle, then go to DONE.
REQ-021 DONE SHALL assert Done=1 for exactly one cycle, then go to IDLE.
REQ-022 Lane order SHALL be big-endian:
  - byte offset 0 is bits[31:24];
  - half offset 0 is bits[31:16].
REQ-023 Latency from the Req-sampling edge to Done SHALL be:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - no-op: 1 cycle.
REQ-024 Req, Addr and WData SHALL be ignored outside IDLE.
REQ-025 A Req still high in the cycle after Done SHALL start a new access.
REQ-026 RData SHALL hold its last value until the next load completes.
REQ-027 lb/lh SHALL sign-extend from bit 7/15; lw SHALL pass the word unchanged.

Reset
REQ-028 Rst_n low SHALL immediately force the state to IDLE and clear RData, Done, Misalign, MemEn, MemWe, MemAddr and MemWData to 0.
REQ-029 Reset mid-operation SHALL abort the access: no MemWe pulse may follow, including after the RD phase of a read-modify-write.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: a word access with Addr[1:0]!=0, or a half access with Addr[0]!=0, SHALL go straight from IDLE to DONE, issue no MemEn, and pulse Misalign with Done.
REQ-031 Macro MISALIGN_TRAP_EN undefined: misaligned low bits SHALL be forced aligned (word: [1:0]=0, half: [0]=0), the access proceeds normally, and Misalign is tied to 0.

Verification
REQ-032 Word 0x10=0x8899AABB, lb Addr=0x11 -> RData=0xFFFFFF99, Done 3 cycles after Req, Stall high for 3 cycles.
REQ-033 Same memory, lh Addr=0x12 -> RData=0xFFFFAABB; lw Addr=0x10 -> RData=0x8899AABB.
REQ-034 sh Addr=0x12, WData=0x00001234 over 0x8899AABB -> one read, then one write of 0x88991234, Done at cycle 4.
REQ-035 sb Addr=0x10, WData=0x000000EE -> word becomes 0xEE99AABB; sw Addr=0x10, WData=0x01020304 -> single write, Done at cycle 2.
REQ-036 lw Addr=0x12 -> with MISALIGN_TRAP_EN: Done+Misalign at cycle 1 and no MemEn; without: reads word 0x10, giving 0x8899AABB.
REQ-037 sh Addr=0x12, Rst_n low during WAIT -> MemWe never asserted, memory stays 0x8899AABB, all outputs 0.
